// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, RV32 opcode
// and funct3/funct7 values, FSM state and latency-class encodings.
// M-extension ops are only produced when ALU_CTRL_MEXT_EN is defined.
package alu_ctrl_pkg;

  localparam int ALU_OP_BITS = 5;

  // ALU control codes; ALU_NOP is the reset and illegal-instruction value
  localparam logic [4:0] ALU_NOP    = 5'd0;
  localparam logic [4:0] ALU_ADD    = 5'd1;
  localparam logic [4:0] ALU_SUB    = 5'd2;
  localparam logic [4:0] ALU_SLL    = 5'd3;
  localparam logic [4:0] ALU_SLT    = 5'd4;
  localparam logic [4:0] ALU_SLTU   = 5'd5;
  localparam logic [4:0] ALU_XOR    = 5'd6;
  localparam logic [4:0] ALU_SRL    = 5'd7;
  localparam logic [4:0] ALU_SRA    = 5'd8;
  localparam logic [4:0] ALU_OR     = 5'd9;
  localparam logic [4:0] ALU_AND    = 5'd10;
  localparam logic [4:0] ALU_PASS_B = 5'd11;
  localparam logic [4:0] ALU_BEQ    = 5'd12;
  localparam logic [4:0] ALU_BNE    = 5'd13;
  localparam logic [4:0] ALU_BLT    = 5'd14;
  localparam logic [4:0] ALU_BGE    = 5'd15;
  localparam logic [4:0] ALU_BLTU   = 5'd16;
  localparam logic [4:0] ALU_BGEU   = 5'd17;
  localparam logic [4:0] ALU_MUL    = 5'd18;
  localparam logic [4:0] ALU_MULH   = 5'd19;
  localparam logic [4:0] ALU_MULHSU = 5'd20;
  localparam logic [4:0] ALU_MULHU  = 5'd21;
  localparam logic [4:0] ALU_DIV    = 5'd22;
  localparam logic [4:0] ALU_DIVU   = 5'd23;
  localparam logic [4:0] ALU_REM    = 5'd24;
  localparam logic [4:0] ALU_REMU   = 5'd25;

  // major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ARITH  = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 for arithmetic
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 for branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 classes
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LAT_SINGLE = 2'd0,
    LAT_MUL    = 2'd1,
    LAT_DIV    = 2'd2
  } lat_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction-field decoder: opcode/funct3/funct7 to ALU code,
// multi-cycle flag, illegal flag and latency class.
// ALU_CTRL_MEXT_EN enables MUL/DIV decode of funct7=0000001.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 5
) (
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                multi_o,
  output logic                illegal_o,
  output lat_e                lat_o
);

  logic [4:0] op;
  logic       f7_ok;

  assign f7_ok    = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
  assign alu_op_o = ALU_OP_W'(op);

  // field decode; anything not matched stays ALU_NOP with illegal set
  always_comb begin
    op        = ALU_NOP;
    multi_o   = 1'b0;
    illegal_o = 1'b0;
    lat_o     = LAT_SINGLE;
    case (opcode_i)
      OPC_ARITH: begin
        if (f7_ok) begin
          case (funct3_i)
            F3_ADD:  op = funct7_i[5] ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = funct7_i[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end
`ifdef ALU_CTRL_MEXT_EN
        else if (funct7_i == F7_MEXT) begin
          multi_o = 1'b1;
          lat_o   = funct3_i[2] ? LAT_DIV : LAT_MUL;
          case (funct3_i)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
          endcase
        end
`endif
        else begin
          illegal_o = 1'b1;
        end
      end
      OPC_IMM: begin
        case (funct3_i)
          F3_ADD:  op = ALU_ADD;  // ADDI has no SUB form
          F3_SLT:  op = ALU_SLT;
          F3_SLTU: op = ALU_SLTU;
          F3_XOR:  op = ALU_XOR;
          F3_OR:   op = ALU_OR;
          F3_AND:  op = ALU_AND;
          // shifts encode the shift type in the upper immediate bits
          F3_SLL: begin
            if (f7_ok) op = ALU_SLL;
            else       illegal_o = 1'b1;
          end
          default: begin
            if (f7_ok) op = funct7_i[5] ? ALU_SRA : ALU_SRL;
            else       illegal_o = 1'b1;
          end
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC: op = ALU_ADD;
      OPC_LUI: op = ALU_PASS_B;
      OPC_BRANCH: begin
        case (funct3_i)
          F3_BEQ:  op = ALU_BEQ;
          F3_BNE:  op = ALU_BNE;
          F3_BLT:  op = ALU_BLT;
          F3_BGE:  op = ALU_BGE;
          F3_BLTU: op = ALU_BLTU;
          F3_BGEU: op = ALU_BGEU;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes an instruction, registers the ALU control
// code and flags, and presents them with a valid/ready handshake. MUL/DIV
// ops wait MUL_LAT/DIV_LAT cycles before becoming valid.
// ALU_CTRL_MEXT_EN enables the M-extension (multi-cycle) path.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 5,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                multi_cycle,
  output logic                illegal
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [5:0]          cnt_ld;
  logic                accept;
  logic                load_out;

  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_multi;
  logic                dec_illegal;
  lat_e                dec_lat;

  logic [ALU_OP_W-1:0] alu_op_q;
  logic                illegal_q;

  alu_op_decode #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .alu_op_o  (dec_op),
    .multi_o   (dec_multi),
    .illegal_o (dec_illegal),
    .lat_o     (dec_lat)
  );

  assign out_valid = (state_q == ST_HOLD);
  assign alu_op    = alu_op_q;
  assign illegal   = illegal_q;
  assign accept    = in_valid && in_ready;
  assign cnt_ld    = (dec_lat == LAT_DIV) ? DIV_LOAD : MUL_LOAD;

  // next state, countdown and handshake; flush dominates everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    in_ready = !flush && ((state_q == ST_IDLE) ||
                          ((state_q == ST_HOLD) && out_ready));
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          // counter was loaded with LAT-1 on accept, so the last WAIT
          // cycle is the one where it reads 1
          if (cnt_q <= 6'd1) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready && !accept) state_d = ST_IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        load_out = 1'b1;
        if (dec_multi && (cnt_ld != 6'd0)) begin
          state_d = ST_WAIT;
          cnt_d   = cnt_ld;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
    end
  end

  // FSM state and countdown register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // output fields only change on accept, so they hold under back-pressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_q  <= ALU_OP_W'(ALU_NOP);
      illegal_q <= 1'b0;
    end else if (load_out) begin
      alu_op_q  <= dec_op;
      illegal_q <= dec_illegal;
    end
  end

`ifdef ALU_CTRL_MEXT_EN
  logic multi_q;

  // multi-cycle flag travels with the held op
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         multi_q <= 1'b0;
    else if (load_out) multi_q <= dec_multi;
  end

  assign multi_cycle = multi_q;
`else
  assign multi_cycle = 1'b0;
`endif

endmodule
